// File: rtl/issue_ctrl.sv
// Issue controller for the dual-slot (upper/lower) pipeline.
// Keeps a per-register countdown scoreboard of pending writebacks and decides,
// each cycle, which slots of the decode bundle advance to exec. Lower never
// issues ahead of upper; a bundle may split (upper now, lower later).
module issue_ctrl #(
  parameter int NREG = 32,
  parameter int LATW = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hold,
  input  logic            flush,
  input  logic            bnd_valid,
  input  logic            u_use_a,
  input  logic            u_use_b,
  input  logic [4:0]      u_ra,
  input  logic [4:0]      u_rb,
  input  logic [4:0]      u_rt,
  input  logic            u_rt_flag,
  input  logic [LATW-1:0] u_lat,
  input  logic            l_use_a,
  input  logic            l_use_b,
  input  logic [4:0]      l_ra,
  input  logic [4:0]      l_rb,
  input  logic [4:0]      l_rt,
  input  logic            l_rt_flag,
  input  logic [LATW-1:0] l_lat,
  output logic            issue_u,
  output logic            issue_l,
  output logic            stall,
  output logic [NREG-1:0] busy
);

  localparam logic [0:0] ST_FULL = 1'b0;
  localparam logic [0:0] ST_HALF = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];

  logic [LATW-1:0] u_lat_e, l_lat_e;
  logic            hz_u, hz_l, intra_hz;

  // A latency of 0 is treated as 1.
  function automatic logic [LATW-1:0] eff_lat(input logic [LATW-1:0] lat);
    return (lat == '0) ? LATW'(1) : lat;
  endfunction

  // A counter at 1 means the write lands at this edge and is forwarded to the
  // consumer, so only counts above 1 block a reader; this gives a consumer
  // issue exactly L cycles after a producer with latency L.
  function automatic logic src_busy(input logic [LATW-1:0] c);
    return c > LATW'(1);
  endfunction

  // Hazard detection against the scoreboard and within the bundle.
  always_comb begin
    u_lat_e  = eff_lat(u_lat);
    l_lat_e  = eff_lat(l_lat);
    hz_u     = (u_use_a && src_busy(cnt_q[u_ra])) ||
               (u_use_b && src_busy(cnt_q[u_rb])) ||
               (u_rt_flag && (cnt_q[u_rt] > u_lat_e));
    intra_hz = (state_q == ST_FULL) && u_rt_flag &&
               ((l_use_a && (l_ra == u_rt)) ||
                (l_use_b && (l_rb == u_rt)) ||
                (l_rt_flag && (l_rt == u_rt)));
    hz_l     = (l_use_a && src_busy(cnt_q[l_ra])) ||
               (l_use_b && src_busy(cnt_q[l_rb])) ||
               (l_rt_flag && (cnt_q[l_rt] > l_lat_e)) ||
               intra_hz;
  end

  // Issue/stall decisions and FSM next state.
  always_comb begin
    issue_u = 1'b0;
    issue_l = 1'b0;
    stall   = 1'b0;
    state_d = state_q;
    if (!rstn) begin
      stall = 1'b1;
    end else if (hold) begin
      stall = 1'b1;
    end else if (flush) begin
      state_d = ST_FULL;
    end else if (bnd_valid) begin
      if (state_q == ST_FULL) begin
        issue_u = !hz_u;
        issue_l = !hz_u && !hz_l;
        stall   = !issue_l;
        if (issue_u && !issue_l) state_d = ST_HALF;
      end else begin
        issue_l = !hz_l;
        stall   = hz_l;
        if (issue_l) state_d = ST_FULL;
      end
    end
  end

  // Scoreboard next state: decrement, then issue loads (lower wins on same rt).
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (hold || cnt_q[r] == '0) cnt_d[r] = cnt_q[r];
      else                        cnt_d[r] = cnt_q[r] - LATW'(1);
    end
    if (issue_u && u_rt_flag) cnt_d[u_rt] = u_lat_e;
    if (issue_l && l_rt_flag) cnt_d[l_rt] = l_lat_e;
  end

  // Debug view of which registers have a pending writeback.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      busy[r] = rstn && (cnt_q[r] != '0);
    end
  end

  // State and scoreboard registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_FULL;
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;

  logic        clk;
  logic        rstn, hold, flush, bnd_valid;
  logic        u_use_a, u_use_b, u_rt_flag;
  logic [4:0]  u_ra, u_rb, u_rt;
  logic [1:0]  u_lat;
  logic        l_use_a, l_use_b, l_rt_flag;
  logic [4:0]  l_ra, l_rb, l_rt;
  logic [1:0]  l_lat;
  logic        issue_u, issue_l, stall;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  issue_ctrl #(.NREG(32), .LATW(2)) dut (
    .clk(clk), .rstn(rstn), .hold(hold), .flush(flush), .bnd_valid(bnd_valid),
    .u_use_a(u_use_a), .u_use_b(u_use_b), .u_ra(u_ra), .u_rb(u_rb), .u_rt(u_rt),
    .u_rt_flag(u_rt_flag), .u_lat(u_lat),
    .l_use_a(l_use_a), .l_use_b(l_use_b), .l_ra(l_ra), .l_rb(l_rb), .l_rt(l_rt),
    .l_rt_flag(l_rt_flag), .l_lat(l_lat),
    .issue_u(issue_u), .issue_l(issue_l), .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_u(input logic ua, input logic [4:0] ra, input logic ub,
                       input logic [4:0] rb, input logic f, input logic [4:0] rt,
                       input logic [1:0] lat);
    u_use_a = ua; u_ra = ra; u_use_b = ub; u_rb = rb;
    u_rt_flag = f; u_rt = rt; u_lat = lat;
  endtask

  task automatic set_l(input logic ua, input logic [4:0] ra, input logic ub,
                       input logic [4:0] rb, input logic f, input logic [4:0] rt,
                       input logic [1:0] lat);
    l_use_a = ua; l_ra = ra; l_use_b = ub; l_rb = rb;
    l_rt_flag = f; l_rt = rt; l_lat = lat;
  endtask

  task automatic clear_slots;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    set_l(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic drain;
    bnd_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    clear_slots();
    repeat (4) next_cycle();
  endtask

  task automatic test_reset;
    logic [2:0] got;
    rstn = 1'b0; hold = 1'b0; flush = 1'b0; bnd_valid = 1'b1;
    set_u(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd1, 2'd1);
    set_l(1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd3, 2'd1);
    for (int i = 0; i < 3; i++) begin
      #3;
      got = {issue_u, issue_l, stall};
      checks++;
      if (got !== 3'b001 || busy !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold%0d: iu/il/st=%b busy=%h expected 001 busy=0", i, got, busy);
      end
      next_cycle();
    end
    rstn = 1'b1;
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL reset_first_issue: iu/il/st=%b expected 110", got);
    end
    next_cycle();
    bnd_valid = 1'b0;
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b000 || busy !== 32'h0000_000A) begin
      errors++;
      $display("FAIL reset_busy_set: iu/il/st=%b busy=%h expected 000 busy=0000000a", got, busy);
    end
    next_cycle();
    #3;
    checks++;
    if (busy !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy_clear: busy=%h expected 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_load_use;
    logic [2:0] got;
    bnd_valid = 1'b1;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd2);
    set_l(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL load_use_producer: iu/il/st=%b expected 110", got);
    end
    next_cycle();
    set_u(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL load_use_stall: iu/il/st=%b expected 001", got);
    end
    next_cycle();
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL load_use_issue: iu/il/st=%b expected 110", got);
    end
    next_cycle();
    drain();
  endtask

  task automatic test_intra_raw;
    logic [2:0] got;
    bnd_valid = 1'b1;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 2'd1);
    set_l(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd8, 2'd1);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b101) begin
      errors++;
      $display("FAIL intra_raw_split: iu/il/st=%b expected 101", got);
    end
    next_cycle();
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL intra_raw_lower: iu/il/st=%b expected 010", got);
    end
    next_cycle();
    set_u(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
    set_l(1'b1, 5'd21, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL intra_raw_back_full: iu/il/st=%b expected 110", got);
    end
    next_cycle();
    drain();
  endtask

  task automatic test_waw;
    logic [2:0] got;
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'b110; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001; exp_seq[3] = 3'b110;
    bnd_valid = 1'b1;
    set_l(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd3);
      else        set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd1);
      #3;
      got = {issue_u, issue_l, stall};
      checks++;
      if (got !== exp_seq[i]) begin
        errors++;
        $display("FAIL waw_cycle%0d: iu/il/st=%b expected %b", i, got, exp_seq[i]);
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_hold_half;
    logic [2:0] got;
    bnd_valid = 1'b1;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 2'd3);
    set_l(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    next_cycle();
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 2'd1);
    set_l(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b101) begin
      errors++;
      $display("FAIL hold_enter_half: iu/il/st=%b expected 101", got);
    end
    next_cycle();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      got = {issue_u, issue_l, stall};
      checks++;
      if (got !== 3'b001 || busy !== 32'h0000_0C00) begin
        errors++;
        $display("FAIL hold_cycle%0d: iu/il/st=%b busy=%h expected 001 busy=00000c00", i, got, busy);
      end
      next_cycle();
    end
    hold = 1'b0;
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b001 || busy !== 32'h0000_0C00) begin
      errors++;
      $display("FAIL hold_release_wait: iu/il/st=%b busy=%h expected 001 busy=00000c00", got, busy);
    end
    next_cycle();
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b010 || busy !== 32'h0000_0400) begin
      errors++;
      $display("FAIL hold_release_issue: iu/il/st=%b busy=%h expected 010 busy=00000400", got, busy);
    end
    next_cycle();
    drain();
  endtask

  task automatic test_flush_half;
    logic [2:0] got;
    bnd_valid = 1'b1;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 2'd3);
    set_l(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b101) begin
      errors++;
      $display("FAIL flush_enter_half: iu/il/st=%b expected 101", got);
    end
    next_cycle();
    flush = 1'b1;
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b000 || busy !== 32'h0000_1000) begin
      errors++;
      $display("FAIL flush_cycle: iu/il/st=%b busy=%h expected 000 busy=00001000", got, busy);
    end
    next_cycle();
    flush = 1'b0;
    set_u(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13, 2'd1);
    set_l(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b101 || busy !== 32'h0000_1000) begin
      errors++;
      $display("FAIL flush_back_full: iu/il/st=%b busy=%h expected 101 busy=00001000", got, busy);
    end
    next_cycle();
    #3;
    got = {issue_u, issue_l, stall};
    checks++;
    if (got !== 3'b010 || busy !== 32'h0000_3000) begin
      errors++;
      $display("FAIL flush_count_on: iu/il/st=%b busy=%h expected 010 busy=00003000", got, busy);
    end
    next_cycle();
    bnd_valid = 1'b0;
    #3;
    checks++;
    if (busy !== 32'h0) begin
      errors++;
      $display("FAIL flush_count_done: busy=%h expected 0", busy);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [2:0] got;
    bnd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_u(1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd14, 2'd1);
      else        set_u(1'b1, 5'(13 + i), 1'b0, 5'd0, 1'b1, 5'(14 + i), 2'd1);
      set_l(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'(20 + i), 2'd1);
      #3;
      got = {issue_u, issue_l, stall};
      checks++;
      if (got !== 3'b110) begin
        errors++;
        $display("FAIL back_to_back%0d: iu/il/st=%b expected 110", i, got);
      end
      next_cycle();
    end
    drain();
  endtask

  initial begin
    rstn = 1'b0; hold = 1'b0; flush = 1'b0; bnd_valid = 1'b0;
    clear_slots();
    test_reset();
    test_load_use();
    test_intra_raw();
    test_waw();
    test_hold_half();
    test_flush_half();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
